// File: rtl/syncram_reader_pkg.sv
// rtl/syncram_reader_pkg.sv - shared types and helpers for the syncram stream reader
package syncram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

    // Count needs one more bit than the pointer so a full FIFO is representable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/syncram_skid_fifo.sv
// rtl/syncram_skid_fifo.sv - first-word-fall-through skid FIFO with occupancy count
//
// Ports:
//   clk       clock
//   resetn    synchronous active-low reset, empties the FIFO
//   push      write push_data this cycle
//   push_data entry to store
//   pop       drop the head entry (ignored when empty)
//   head_data current head entry, valid while count != 0
//   count     number of stored entries
module syncram_skid_fifo
    import syncram_reader_pkg::*;
#(
    parameter int DW    = 33,
    parameter int DEPTH = 4,
    localparam int CW   = fifo_cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // The reader's credit check must make this unreachable.
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(push && count == CW'(DEPTH)));
        end
    end

endmodule

// File: rtl/syncram_stream_reader.sv
// rtl/syncram_stream_reader.sv - burst reader for a sync RAM read port with valid/ready output
//
// Ports:
//   clock0      clock, also the RAM read-port clock
//   sclr_n      synchronous active-low reset
//   cmd_valid   burst request valid
//   cmd_ready   command accepted (high only when idle)
//   cmd_addr    first word address
//   cmd_len     burst length in words, 0 = empty burst
//   ram_address RAM read address (registered)
//   ram_rden    RAM read enable
//   ram_q       RAM read data, READ_LATENCY cycles after rden
//   out_valid   stream word valid
//   out_ready   downstream accepts the word
//   out_data    stream word
//   out_last    final word of the burst
//   busy        burst in progress
module syncram_stream_reader
    import syncram_reader_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int WIDTHAD      = 10,
    parameter int READ_LATENCY = 2,
    parameter int LEN_W        = 16,
    parameter int SKID_DEPTH   = 4
) (
    input  logic               clock0,
    input  logic               sclr_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTHAD-1:0] cmd_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    output logic [WIDTHAD-1:0] ram_address,
    output logic               ram_rden,
    input  logic [WIDTH-1:0]   ram_q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic               busy
);

    localparam int CW = fifo_cnt_w(SKID_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(SKID_DEPTH);

    rd_state_t               state;
    logic [LEN_W-1:0]        remaining;
    logic [READ_LATENCY-1:0] pipe_v;
    logic [READ_LATENCY-1:0] pipe_l;
    logic [CW-1:0]           fifo_count;
    logic [CW-1:0]           inflight;
    logic [WIDTH:0]          head;
    logic                    tail_v;
    logic                    tail_l;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    credit;
    logic                    last_issue;

    assign cmd_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign tail_v     = pipe_v[READ_LATENCY-1];
    assign tail_l     = pipe_l[READ_LATENCY-1];
    assign fifo_empty = (fifo_count == '0);
    assign last_issue = (remaining == LEN_W'(1));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_v[i]);
        end
    end

    // Registered counts only: a pop in this cycle frees its slot next cycle.
    assign credit   = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_C;
    assign ram_rden = (state == ST_ISSUE) && credit;

    // When the FIFO is empty the returning RAM word is presented directly, so
    // first data appears the cycle ram_q becomes valid; it is only stored if
    // downstream does not take it straight away.
    assign out_valid = !fifo_empty || tail_v;
    assign out_data  = fifo_empty ? ram_q  : head[WIDTH-1:0];
    assign out_last  = fifo_empty ? tail_l : head[WIDTH];
    assign fifo_pop  = out_ready && !fifo_empty;
    assign fifo_push = tail_v && !(fifo_empty && out_ready);

    syncram_skid_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clock0),
        .resetn    (sclr_n),
        .push      (fifo_push),
        .push_data ({tail_l, ram_q}),
        .pop       (fifo_pop),
        .head_data (head),
        .count     (fifo_count)
    );

    always_ff @(posedge clock0) begin
        if (!sclr_n) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            ram_address <= '0;
            pipe_v      <= '0;
            pipe_l      <= '0;
        end else begin
            // Stage 0 lines up with the RAM sampling address/rden; the tail
            // stage lines up with ram_q carrying that word.
            pipe_v[0] <= ram_rden;
            pipe_l[0] <= ram_rden && last_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        ram_address <= cmd_addr;
                        remaining   <= cmd_len;
                        state       <= (cmd_len == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ram_rden) begin
                        ram_address <= ram_address + WIDTHAD'(1);
                        remaining   <= remaining - LEN_W'(1);
                        if (last_issue) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pipe_v == '0 && fifo_empty) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_syncram_stream_reader.sv
// tb/tb_syncram_stream_reader.sv - scoreboard bench for syncram_stream_reader
module tb_syncram_stream_reader;

    localparam int W  = 32;
    localparam int AW = 10;
    localparam int LW = 16;
    localparam int D  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          sclr_n;
    logic          cmd_valid, cmd_ready, cmd_valid_b, cmd_ready_b;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] ram_address, ram_address_b;
    logic          ram_rden, ram_rden_b;
    logic [W-1:0]  ram_q, ram_q_b;
    logic          out_valid, out_valid_b, out_ready;
    logic          out_last, out_last_b, busy, busy_b;
    logic [W-1:0]  out_data, out_data_b;

    syncram_stream_reader #(.WIDTH(W), .WIDTHAD(AW), .READ_LATENCY(2), .LEN_W(LW), .SKID_DEPTH(D)) dut (
        .clock0(clk), .sclr_n(sclr_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_address(ram_address), .ram_rden(ram_rden),
        .ram_q(ram_q), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    syncram_stream_reader #(.WIDTH(W), .WIDTHAD(AW), .READ_LATENCY(1), .LEN_W(LW), .SKID_DEPTH(D)) dut_b (
        .clock0(clk), .sclr_n(sclr_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_address(ram_address_b), .ram_rden(ram_rden_b),
        .ram_q(ram_q_b), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_last(out_last_b), .busy(busy_b)
    );

    // RAM models: latency 2 registers the output, latency 1 does not.
    logic [W-1:0]  mem [1 << AW];
    logic [AW-1:0] a_r, a_r_b;
    logic [W-1:0]  q_r;
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = W'(i) + 32'h100;
    always @(posedge clk) begin
        if (ram_rden) a_r <= ram_address;
        q_r <= mem[a_r];
        if (ram_rden_b) a_r_b <= ram_address_b;
    end
    assign ram_q   = q_r;
    assign ram_q_b = mem[a_r_b];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [W:0]    exp_q[$];
    logic [W:0]    exp_b[$];
    logic [AW-1:0] addr_q[$];
    logic [W:0]    e, e_b, hold_val;
    logic          hold_pend = 1'b0;
    logic          arm = 1'b0, arm_b = 1'b0;
    int pc = 0, hs_pc = 0, hs_b = 0, lat = -1, lat_b = -1;
    int beats = 0, beats_b = 0, issued = 0, accepted = 0, last_beat_pc = 0;
    logic bp = 1'b0;
    int   ph = 0;

    always @(posedge clk) pc++;

    always @(negedge clk) begin
        if (sclr_n) begin
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_beat", {out_last, out_data}, hold_val);
            end
            if (arm && out_valid) begin
                lat = pc - hs_pc;
                arm = 1'b0;
            end
            if (out_valid && out_ready) begin
                accepted++;
                beats++;
                last_beat_pc = pc;
                if (exp_q.size() == 0) chk("beat_extra", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("data", out_data, e[W-1:0]);
                    chk("last", out_last, e[W]);
                end
            end
            if (ram_rden) begin
                issued++;
                if (addr_q.size() == 0) chk("rd_extra", 1, 0);
                else chk("rd_addr", ram_address, addr_q.pop_front());
                chk("credit", ((issued - accepted) <= D) ? 1 : 0, 1);
            end
            if (arm_b && out_valid_b) begin
                lat_b = pc - hs_b;
                arm_b = 1'b0;
            end
            if (out_valid_b && out_ready) begin
                beats_b++;
                if (exp_b.size() == 0) chk("b_beat_extra", 1, 0);
                else begin
                    e_b = exp_b.pop_front();
                    chk("b_data", out_data_b, e_b[W-1:0]);
                    chk("b_last", out_last_b, e_b[W]);
                end
            end
        end
        hold_pend = sclr_n && out_valid && !out_ready;
        hold_val  = {out_last, out_data};
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp) begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic push_exp(input logic [AW-1:0] a, input int n, input logic to_b);
        logic [AW-1:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + AW'(i);
            if (to_b) exp_b.push_back({(i == n - 1), 32'h100 + W'(ai)});
            else begin
                exp_q.push_back({(i == n - 1), 32'h100 + W'(ai)});
                addr_q.push_back(ai);
            end
        end
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input int n);
        int k = 0;
        push_exp(a, n, 1'b0);
        cmd_addr  = a;
        cmd_len   = LW'(n);
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_accept", cmd_ready, 1);
        hs_pc = pc;
        lat   = -1;
        arm   = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0 || addr_q.size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(tag, (k < 400) ? 1 : 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, i0, k;
        sclr_n = 1'b0; cmd_valid = 1'b0; cmd_valid_b = 1'b0; cmd_addr = '0; cmd_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rden", ram_rden, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 sclr_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;

        b0 = beats;
        send_cmd(10'h010, 4);
        wait_done("basic_done");
        chk("basic_lat", lat, 3);
        chk("basic_beats", beats - b0, 4);
        chk("basic_span", last_beat_pc - hs_pc, 6);

        b0 = beats;
        bp = 1'b1;
        send_cmd(10'h020, 16);
        wait_done("bp_done");
        bp = 1'b0;
        chk("bp_beats", beats - b0, 16);

        b0 = beats;
        send_cmd(10'h3FE, 4);
        wait_done("wrap_done");
        chk("wrap_beats", beats - b0, 4);

        b0 = beats;
        i0 = issued;
        send_cmd(10'h055, 0);
        @(negedge clk);
        chk("zero_ready_c1", cmd_ready, 0);
        @(negedge clk);
        chk("zero_ready_c2", cmd_ready, 1);
        repeat (4) @(negedge clk);
        chk("zero_rden", issued - i0, 0);
        chk("zero_beats", beats - b0, 0);
        @(posedge clk);
        #1;

        b0 = beats;
        send_cmd(10'h100, 32);
        k = 0;
        while (beats - b0 < 10 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_progress", (k < 200) ? 1 : 0, 1);
        @(posedge clk);
        #1 sclr_n = 1'b0;
        @(posedge clk);
        #1 sclr_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        issued = 0;
        accepted = 0;
        @(negedge clk);
        chk("mid_valid", out_valid, 0);
        chk("mid_rden", ram_rden, 0);
        chk("mid_cmd_ready", cmd_ready, 1);
        chk("mid_busy", busy, 0);
        @(posedge clk);
        #1;
        b0 = beats;
        send_cmd(10'h000, 2);
        wait_done("mid_done");
        chk("mid_beats", beats - b0, 2);

        push_exp(10'h000, 3, 1'b1);
        cmd_addr = '0;
        cmd_len = LW'(3);
        cmd_valid_b = 1'b1;
        @(negedge clk);
        chk("b_accept", cmd_ready_b, 1);
        hs_b  = pc;
        arm_b = 1'b1;
        @(posedge clk);
        #1 cmd_valid_b = 1'b0;
        k = 0;
        @(negedge clk);
        while ((busy_b || exp_b.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("b_done", (k < 200) ? 1 : 0, 1);
        chk("b_lat", lat_b, 2);
        chk("b_beats", beats_b, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
